// File: rtl/fpu_seq_ctrl_pkg.sv
// Shared definitions for the FPU sequencer: state encoding, F-type opcode
// and err_sticky bit positions.
package fpu_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_EXEC  = 2'd2,
    S_WB    = 2'd3
  } fpu_state_e;

  localparam logic [2:0] OP_FINST = 3'b110;

  localparam int unsigned ERR_FPU_BIT = 0;
  localparam int unsigned ERR_TMO_BIT = 1;

  function automatic logic is_finst(input logic [2:0] op);
    return op == OP_FINST;
  endfunction

endpackage

// File: rtl/fpu_seq_ctrl_if.sv
// FPU request/done handshake and register-file write-port request, seen from
// the sequencer (master) and from the FPU / write-port arbiter (slave).
interface fpu_seq_ctrl_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
);
  logic              fpu_req;
  logic [2:0]        fpu_funct;
  logic              fpu_ack;
  logic              fpu_done;
  logic              fpu_err;
  logic [XLEN-1:0]   fpu_result;

  logic              wb_req;
  logic              wb_grant;
  logic [REG_AW-1:0] wb_rd;
  logic [XLEN-1:0]   wb_data;

  modport master (
    output fpu_req, fpu_funct, wb_req, wb_rd, wb_data,
    input  fpu_ack, fpu_done, fpu_err, fpu_result, wb_grant
  );

  modport slave (
    input  fpu_req, fpu_funct, wb_req, wb_rd, wb_data,
    output fpu_ack, fpu_done, fpu_err, fpu_result, wb_grant
  );
endinterface

// File: rtl/fpu_seq_ctrl_wdog.sv
// EXEC-phase watchdog: saturating cycle counter that flags expiry once it has
// sat at TIMEOUT-1 while enabled.
module fpu_wdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned    CW   = $clog2(TIMEOUT);
  localparam logic [CW-1:0]  LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/fpu_seq_ctrl.sv
// Single-outstanding F-instruction sequencer: FPU handshake, destination
// hazard stalls and result writeback through the shared register write port.
module fpu_seq_ctrl
  import fpu_ctrl_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              id_valid,
  input  logic [2:0]        id_op,
  input  logic [2:0]        id_funct,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              flush,
  output logic              stall_o,

  fpu_seq_ctrl_if.master    bus,

  output logic              busy,
  output logic [1:0]        err_sticky,
  input  logic              err_clr
);

  fpu_state_e        state_q, state_d;
  logic [REG_AW-1:0] pend_rd_q, pend_rd_d;
  logic [2:0]        funct_q, funct_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;
  logic              fpu_req_q, fpu_req_d;
  logic              wb_req_q, wb_req_d;
  logic [1:0]        err_q, err_d;
  logic [1:0]        err_set;

  logic wdog_clear;
  logic wdog_en;
  logic wdog_expired;

  logic not_idle;
  logic pend_live;
  logic haz_struct;
  logic haz_raw;
  logic haz_waw;

  assign wdog_clear = (state_q == S_ISSUE) && bus.fpu_ack;
  assign wdog_en    = (state_q == S_EXEC);

  fpu_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (wdog_clear),
    .enable (wdog_en),
    .expired(wdog_expired)
  );

  // Hazards are only meaningful while an operation is pending; x0 never aliases.
  assign not_idle   = (state_q != S_IDLE);
  assign pend_live  = (pend_rd_q != '0);
  assign haz_struct = is_finst(id_op);
  assign haz_raw    = pend_live && ((id_rs1 == pend_rd_q) || (id_rs2 == pend_rd_q));
  assign haz_waw    = pend_live && (id_rd == pend_rd_q);

  always_comb begin
    stall_o = 1'b0;
    if (id_valid && !flush && not_idle) begin
      stall_o = haz_struct || haz_raw || haz_waw;
    end
  end

  always_comb begin
    state_d   = state_q;
    pend_rd_d = pend_rd_q;
    funct_d   = funct_q;
    wb_data_d = wb_data_q;
    err_set   = '0;

    unique case (state_q)
      S_IDLE: begin
        if (id_valid && is_finst(id_op) && !flush) begin
          state_d   = S_ISSUE;
          pend_rd_d = id_rd;
          funct_d   = id_funct;
        end
      end

      // An ack coinciding with flush means the FPU already took the op.
      S_ISSUE: begin
        if (bus.fpu_ack) begin
          state_d = S_EXEC;
        end else if (flush) begin
          state_d = S_IDLE;
        end
      end

      S_EXEC: begin
        if (bus.fpu_done) begin
          if (bus.fpu_err) begin
            err_set[ERR_FPU_BIT] = 1'b1;
            state_d              = S_IDLE;
          end else begin
            wb_data_d = bus.fpu_result;
            state_d   = (pend_rd_q == '0) ? S_IDLE : S_WB;
          end
        end else if (wdog_expired) begin
          err_set[ERR_TMO_BIT] = 1'b1;
          state_d              = S_IDLE;
        end
      end

      S_WB: begin
        if (bus.wb_grant) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    fpu_req_d = (state_d == S_ISSUE);
    wb_req_d  = (state_d == S_WB);
    err_d     = (err_clr ? 2'b00 : err_q) | err_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pend_rd_q <= '0;
      funct_q   <= '0;
      wb_data_q <= '0;
      fpu_req_q <= 1'b0;
      wb_req_q  <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      pend_rd_q <= pend_rd_d;
      funct_q   <= funct_d;
      wb_data_q <= wb_data_d;
      fpu_req_q <= fpu_req_d;
      wb_req_q  <= wb_req_d;
      err_q     <= err_d;
    end
  end

  assign bus.fpu_req   = fpu_req_q;
  assign bus.fpu_funct = funct_q;
  assign bus.wb_req    = wb_req_q;
  assign bus.wb_rd     = pend_rd_q;
  assign bus.wb_data   = wb_data_q;

  assign busy       = not_idle;
  assign err_sticky = err_q;

endmodule

// File: tb/tb_fpu_seq_ctrl.sv
// Bench for fpu_seq_ctrl: behavioural FPU and write-port arbiter, with a
// queue of expected writebacks checked whenever the block drives wb_req.
module tb_fpu_seq_ctrl;
  import fpu_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       id_valid, flush, err_clr;
  logic [2:0] id_op, id_funct;
  logic [4:0] id_rd, id_rs1, id_rs2;
  logic       stall_o, busy;
  logic [1:0] err_sticky;

  fpu_seq_ctrl_if #(.XLEN(32), .REG_AW(5)) bus ();

  fpu_seq_ctrl #(.XLEN(32), .REG_AW(5), .TIMEOUT(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .id_valid  (id_valid),
    .id_op     (id_op),
    .id_funct  (id_funct),
    .id_rd     (id_rd),
    .id_rs1    (id_rs1),
    .id_rs2    (id_rs2),
    .flush     (flush),
    .stall_o   (stall_o),
    .bus       (bus),
    .busy      (busy),
    .err_sticky(err_sticky),
    .err_clr   (err_clr)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_exp_t;

  wb_exp_t sb_q[$];

  int total = 0;
  int bad   = 0;

  // Knobs for the behavioural FPU and arbiter.
  int          ack_dly   = 0;
  int          done_dly  = 1;
  int          grant_dly = 0;
  logic        done_err  = 1'b0;
  logic [31:0] res       = '0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // FPU: ack in request cycle ack_dly+1, done in EXEC cycle done_dly.
  initial begin : fpu_model
    int   req_cnt;
    int   exec_cnt;
    logic exec_on;
    logic req_prev;
    req_cnt = 0; exec_cnt = 0; exec_on = 1'b0; req_prev = 1'b0;
    bus.fpu_ack = 1'b0; bus.fpu_done = 1'b0; bus.fpu_err = 1'b0; bus.fpu_result = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        req_cnt = 0; exec_cnt = 0; exec_on = 1'b0; req_prev = 1'b0;
        bus.fpu_ack = 1'b0; bus.fpu_done = 1'b0; bus.fpu_err = 1'b0;
      end else begin
        if (bus.fpu_ack && req_prev) begin
          exec_on  = 1'b1;
          exec_cnt = 0;
        end
        bus.fpu_done   = 1'b0;
        bus.fpu_err    = 1'b0;
        bus.fpu_result = res;
        if (exec_on) begin
          exec_cnt++;
          if (exec_cnt == done_dly) begin
            bus.fpu_done = 1'b1;
            bus.fpu_err  = done_err;
            exec_on      = 1'b0;
          end
        end
        req_prev = bus.fpu_req;
        if (bus.fpu_req) req_cnt++;
        else             req_cnt = 0;
        bus.fpu_ack = bus.fpu_req && (req_cnt == ack_dly + 1);
      end
    end
  end

  // Write-port arbiter: grants after grant_dly refused cycles; scoreboard check.
  initial begin : wb_model
    int wcnt;
    wcnt = 0;
    bus.wb_grant = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.wb_req) wcnt++;
      else            wcnt = 0;
      bus.wb_grant = bus.wb_req && (wcnt > grant_dly);
      if (sb_q.size() == 0) begin
        chk("wb_spurious", bus.wb_req, 1'b0);
      end else if (bus.wb_req) begin
        chk("wb_rd", bus.wb_rd, sb_q[0].rd);
        chk("wb_data", bus.wb_data, sb_q[0].data);
        if (bus.wb_grant) void'(sb_q.pop_front());
      end
    end
  end

  initial begin : global_guard
    #300000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  task automatic clear_id();
    id_valid = 1'b0; id_op = 3'b000; id_funct = 3'b000;
    id_rd = '0; id_rs1 = '0; id_rs2 = '0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [2:0] funct, input logic expect_wb);
    id_valid = 1'b1; id_op = OP_FINST; id_funct = funct;
    id_rd = rd; id_rs1 = '0; id_rs2 = '0;
    if (expect_wb) sb_q.push_back('{rd: rd, data: res});
    #1 chk("accept_stall", stall_o, 1'b0);
    tick();
    clear_id();
    chk("issue_req", bus.fpu_req, 1'b1);
    chk("issue_funct", bus.fpu_funct, funct);
    chk("issue_busy", busy, 1'b1);
  endtask

  task automatic run_idle(input int budget, output int bcyc, output int wcyc);
    bcyc = 0;
    wcyc = 0;
    while (busy && bcyc < budget) begin
      bcyc++;
      if (bus.wb_req) wcyc++;
      tick();
    end
    chk("idle_reached", busy, 1'b0);
  endtask

  initial begin : main
    int b, w, n;
    clear_id();
    flush = 1'b0;
    err_clr = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_fpu_req", bus.fpu_req, 1'b0);
    chk("rst_funct", bus.fpu_funct, 3'b000);
    chk("rst_wb_req", bus.wb_req, 1'b0);
    chk("rst_wb_rd", bus.wb_rd, 5'd0);
    chk("rst_wb_data", bus.wb_data, 32'd0);
    chk("rst_err", err_sticky, 2'b00);
    chk("rst_stall", stall_o, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Basic operation
    ack_dly = 1; done_dly = 5; grant_dly = 0; res = 32'h3F80_0000;
    issue(5'd3, 3'd2, 1'b1);
    run_idle(100, b, w);
    chk("basic_busy_len", b, 8);
    chk("basic_wb_cycles", w, 1);

    // RAW hazard on rs2
    ack_dly = 0; done_dly = 3; res = 32'h4000_0000;
    issue(5'd3, 3'd1, 1'b1);
    id_valid = 1'b1; id_op = 3'b000; id_rs1 = 5'd1; id_rs2 = 5'd3; id_rd = 5'd9;
    n = 0;
    while (busy && n < 50) begin
      #1 chk("raw_stall", stall_o, 1'b1);
      n++;
      tick();
    end
    #1 chk("raw_release", stall_o, 1'b0);
    chk("raw_len", n, 5);
    clear_id();
    tick();

    // No hazard with unrelated sources
    res = 32'h4040_0000;
    issue(5'd3, 3'd1, 1'b1);
    id_valid = 1'b1; id_op = 3'b000; id_rs1 = 5'd4; id_rs2 = 5'd4; id_rd = 5'd9;
    n = 0;
    while (busy && n < 50) begin
      #1 chk("nohaz_stall", stall_o, 1'b0);
      n++;
      tick();
    end
    clear_id();
    chk("nohaz_idle", busy, 1'b0);

    // WAW hazard
    res = 32'h4080_0000;
    issue(5'd3, 3'd0, 1'b1);
    id_valid = 1'b1; id_op = 3'b000; id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = 5'd3;
    #1 chk("waw_stall", stall_o, 1'b1);
    clear_id();
    run_idle(100, b, w);

    // Write-port contention with a second F-instruction waiting
    done_dly = 2; grant_dly = 4; res = 32'hC0A0_0000;
    issue(5'd5, 3'd4, 1'b1);
    id_valid = 1'b1; id_op = OP_FINST; id_funct = 3'd5; id_rd = 5'd6;
    n = 0; w = 0;
    while (busy && n < 50) begin
      if (bus.wb_req) w++;
      #1 chk("struct_stall", stall_o, 1'b1);
      n++;
      tick();
    end
    chk("wb_hold_cycles", w, 5);
    chk("contention_len", n, 8);
    #1 chk("struct_release", stall_o, 1'b0);
    res = 32'h4120_0000;
    grant_dly = 0;
    sb_q.push_back('{rd: 5'd6, data: res});
    tick();
    clear_id();
    chk("b2b_req", bus.fpu_req, 1'b1);
    chk("b2b_funct", bus.fpu_funct, 3'd5);
    run_idle(100, b, w);

    // Flush before ack abandons the op
    ack_dly = 3;
    issue(5'd4, 3'd0, 1'b0);
    flush = 1'b1;
    id_valid = 1'b1; id_op = OP_FINST; id_rd = 5'd4;
    #1 chk("flush_stall", stall_o, 1'b0);
    tick();
    flush = 1'b0;
    clear_id();
    chk("flush_idle", busy, 1'b0);
    chk("flush_req", bus.fpu_req, 1'b0);
    repeat (6) tick();

    // Flush during EXEC is ignored
    ack_dly = 0; done_dly = 4; res = 32'h3F00_0000;
    issue(5'd7, 3'd6, 1'b1);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_exec_busy", busy, 1'b1);
    run_idle(100, b, w);
    chk("flush_exec_wb", w, 1);

    // FPU exception
    done_dly = 3; done_err = 1'b1;
    issue(5'd8, 3'd1, 1'b0);
    run_idle(100, b, w);
    done_err = 1'b0;
    chk("err_fpu", err_sticky, 2'b01);
    chk("err_fpu_no_wb", w, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_clr_fpu", err_sticky, 2'b00);

    // Timeout, with a late done afterwards
    done_dly = 70;
    issue(5'd9, 3'd2, 1'b0);
    run_idle(200, b, w);
    chk("tmo_len", b, 65);
    chk("tmo_err", err_sticky, 2'b10);
    repeat (10) tick();
    chk("late_done_ignored", err_sticky, 2'b10);
    chk("late_done_idle", busy, 1'b0);

    // Set beats clear in the same cycle
    done_dly = 3; done_err = 1'b1; err_clr = 1'b1;
    issue(5'd10, 3'd0, 1'b0);
    run_idle(100, b, w);
    chk("err_set_wins", err_sticky, 2'b01);
    err_clr = 1'b0; done_err = 1'b0;

    // Both bits, then clear
    done_dly = 70;
    issue(5'd12, 3'd3, 1'b0);
    run_idle(200, b, w);
    chk("err_both", err_sticky, 2'b11);
    repeat (10) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_clr_both", err_sticky, 2'b00);

    // rd=0: no writeback, x0 never hazards
    done_dly = 2; res = 32'hDEAD_BEEF;
    issue(5'd0, 3'd3, 1'b0);
    id_valid = 1'b1; id_op = 3'b000; id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0;
    #1 chk("rd0_no_stall", stall_o, 1'b0);
    clear_id();
    run_idle(100, b, w);
    chk("rd0_len", b, 3);
    chk("rd0_no_wb", w, 0);

    // Asynchronous reset while in WB
    grant_dly = 100; res = 32'h1234_5678;
    issue(5'd2, 3'd1, 1'b1);
    n = 0;
    while (!bus.wb_req && n < 20) begin
      n++;
      tick();
    end
    chk("rst_wb_seen", bus.wb_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wb_req", bus.wb_req, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_wb_data", bus.wb_data, 32'd0);
    chk("arst_wb_rd", bus.wb_rd, 5'd0);
    sb_q.delete();
    @(negedge clk) rst_n = 1'b1;
    grant_dly = 0;
    tick();

    // Recovery after reset
    res = 32'h0BAD_F00D;
    issue(5'd11, 3'd7, 1'b1);
    run_idle(100, b, w);
    chk("recover_wb", w, 1);

    repeat (3) tick();
    chk("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpu_seq_ctrl.md
# fpu_seq_ctrl

Sequencer for the multi-cycle FPU behind the pipelined CPU's F-type instructions (opcode 3'b110). It accepts one F-instruction from decode, runs the FPU request/done handshake and guards the pending destination register against hazards with decode stalls. It also arbitrates the FPU result onto the shared register-file write port, where the integer pipe has priority. Only one FPU operation is in flight at a time.

## Interface
Parameters:
- XLEN, 32, datapath width
- REG_AW, 5, register address width
- TIMEOUT, 64, maximum cycles allowed in EXEC before abort (≥2)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  decode stage holds a valid instruction
- id_op  in  3  decode opcode
- id_funct  in  3  FPU function field
- id_rd, id_rs1, id_rs2  in  REG_AW  decode register addresses
- flush  in  1  pipeline flush from branch/jump resolution
- stall_o  out  1  freeze fetch/decode (combinational)
- fpu_req  out  1  operation request to FPU
- fpu_funct  out  3  latched function
- fpu_ack  in  1  FPU accepted request
- fpu_done  in  1  result valid, one-cycle pulse
- fpu_err  in  1  exception, qualified by fpu_done
- fpu_result  in  XLEN  FPU result
- wb_req  out  1  request for the register write port
- wb_grant  in  1  write port granted this cycle
- wb_rd  out  REG_AW  destination
- wb_data  out  XLEN  latched result
- busy  out  1  state ≠ IDLE
- err_sticky  out  2  bit0 FPU exception, bit1 timeout
- err_clr  in  1  clears err_sticky

## Operation
- The four states are IDLE, ISSUE, EXEC and WB.
- **IDLE → ISSUE:** occurs when id_valid, id_op==3'b110 and !flush. The block latches pend_rd←id_rd and fpu_funct←id_funct. stall_o is not raised in the accept cycle, so the instruction leaves decode.
- **ISSUE:**
  - fpu_req is held high until fpu_ack. A cycle with fpu_req&&fpu_ack moves to EXEC and clears the cycle counter.
  - flush in ISSUE before ack drops fpu_req and returns to IDLE with no writeback.
- **EXEC:**
  - On fpu_done with !fpu_err, the block latches wb_data←fpu_result. It then goes to WB, or to IDLE if pend_rd==0.
  - On fpu_done with fpu_err, it sets err_sticky[0], discards the result and returns to IDLE.
  - If the counter reaches TIMEOUT-1 without done, it sets err_sticky[1] and returns to IDLE. A fpu_done arriving later is ignored.
  - flush is ignored, because the F-instruction is older than the flushing branch.
- **WB:** wb_req is held high with wb_rd=pend_rd until wb_grant, then the block returns to IDLE. flush is ignored.
- **stall_o:** asserted when id_valid and any of the following hold:
  - state≠IDLE and id_op==3'b110 (structural hazard).
  - state≠IDLE and id_rs1 or id_rs2 equals pend_rd, with pend_rd≠0 (RAW hazard).
  - state≠IDLE and id_rd==pend_rd, with pend_rd≠0 (WAW hazard).
  - stall_o is forced low while flush is high.
- **err_sticky:** err_clr clears it. A set event in the same cycle as err_clr wins.

## Timing
- Reset values: state IDLE, all outputs 0, pend_rd 0, counter 0.
- Accept at edge N puts fpu_req high during cycle N+1, registered.
- The ack cycle is the last cycle fpu_req is high. fpu_done is legal at the earliest one cycle after ack.
- A done at edge M puts wb_req high during cycle M+1, with wb_data already valid.
- wb_grant at edge G puts the block in IDLE in cycle G+1. A stalled F-instruction is accepted at edge G+1, so the minimum issue-to-issue interval is 4 cycles plus FPU latency plus grant delay.
- Asynchronous reset mid-operation returns the block to IDLE immediately with all outputs 0. The external FPU is reset by the same rst_n.
- The timeout counter is $clog2(TIMEOUT) bits, saturating, and is active only in EXEC.

## Structure
- Shared package fpu_ctrl_pkg holds:
  - the state enum,
  - OP_FINST=3'b110,
  - the err_sticky bit indices.
- Sub-module fpu_wdog holds the EXEC cycle counter and timeout compare. Its ports are clear, enable and expired.

## Test plan
- Basic op: F-inst rd=3, ack after 1 cycle, done after 5 cycles with result 0x3F800000, wb_grant immediate. Expect wb_rd=3, wb_data=0x3F800000, and busy high for exactly 8 cycles.
- RAW hazard: while EXEC with pend_rd=3, decode presents rs2=3. Expect stall_o=1 until the cycle after grant. With rs1=rs2=4 instead, expect stall_o=0.
- Write-port contention: hold wb_grant=0 for 4 cycles in WB. Expect wb_req held, wb_data stable, and a second F-inst stalled throughout.
- Flush: flush in ISSUE before ack returns the block to IDLE with no wb_req. Flush in EXEC still produces writeback.
- Errors:
  - fpu_err with done sets err_sticky=01 and gives no wb_req.
  - No done for TIMEOUT=64 cycles sets err_sticky=10 and returns to IDLE.
  - err_clr clears both bits.
- rd=0 and reset: F-inst with rd=0 completes with no wb_req. rst_n asserted in WB clears wb_req and busy immediately.
